// File: rtl/mire_wshb_writer_pkg.sv
// Shared types and constants for the test-pattern Wishbone writer.
package mire_wshb_writer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    RELEASE
  } wr_state_t;

  localparam logic [2:0]  CTI_INCR  = 3'b010;
  localparam logic [2:0]  CTI_END   = 3'b111;
  localparam logic [23:0] RGB_WHITE = 24'hFFFFFF;
  localparam int          GRID_W    = 4;
  localparam int          CW        = 16;

  function automatic logic [23:0] bar_rgb(
    input logic [2:0] idx
  );
    return {{8{idx[2]}}, {8{idx[1]}}, {8{idx[0]}}};
  endfunction

endpackage

// File: rtl/mire_pattern.sv
// Colour bars plus grid, from pixel coordinates.
// MIRE_ANIM_EN: bars scroll by frame_cnt pixels.
module mire_pattern
  import mire_wshb_writer_pkg::*;
(
  input  logic [9:0]        x,
  input  logic [GRID_W-1:0] y,
`ifdef MIRE_ANIM_EN
  input  logic [9:0]        frame_cnt,
`endif
  output logic [23:0]       rgb
);

  logic [9:0] xs;
  logic       pat_unused;

`ifdef MIRE_ANIM_EN
  assign xs = x + frame_cnt;
`else
  assign xs = x;
`endif

  // Grid lines stay put; only the bars move.
  always_comb begin
    rgb = bar_rgb(xs[9:7]);
    if (x[GRID_W-1:0] == '0 || y == '0)
      rgb = RGB_WHITE;
  end

  assign pat_unused = ^xs[6:0];

endmodule

// File: rtl/mire_wshb_writer.sv
// Wishbone master filling the framebuffer with a test pattern.
// MIRE_ANIM_EN: horizontally scrolling bars.
module mire_wshb_writer
  import mire_wshb_writer_pkg::*;
#(
  parameter int HDISP     = 800,
  parameter int VDISP     = 480,
  parameter int BURST_LEN = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [31:0] adr,
  output logic [31:0] dat_ms,
  output logic [3:0]  sel,
  output logic        we,
  output logic        cyc,
  output logic        stb,
  output logic [2:0]  cti,
  output logic [1:0]  bte,
  input  logic        ack,
  output logic        frame_done
);

  localparam int BW = $clog2(BURST_LEN);

  wr_state_t     state, state_nx;
  logic [CW-1:0] x, y;
  logic [BW-1:0] beat;
  logic          x_end, last_pix, last_beat, acc;
  logic [23:0]   rgb;

  assign x_end     = x == CW'(HDISP - 1);
  assign last_pix  = x_end && (y == CW'(VDISP - 1));
  assign last_beat = (beat == BW'(BURST_LEN - 1)) || last_pix;
  assign acc       = (state == WRITE) && ack;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (en) state_nx = WRITE;
      WRITE:   if (ack && last_beat) state_nx = RELEASE;
      RELEASE: state_nx = en ? WRITE : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      adr        <= '0;
      beat       <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      frame_done <= acc && last_pix;
      if (acc) begin
        beat <= last_beat ? '0 : beat + BW'(1);
        if (last_pix) begin
          x   <= '0;
          y   <= '0;
          adr <= '0;
        end else begin
          adr <= adr + 32'd4;
          if (x_end) begin
            x <= '0;
            y <= y + CW'(1);
          end else begin
            x <= x + CW'(1);
          end
        end
      end
    end
  end

`ifdef MIRE_ANIM_EN
  logic [9:0] frame_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      frame_cnt <= '0;
    else if (acc && last_pix)
      frame_cnt <= frame_cnt + 10'd1;
  end

  mire_pattern u_pat (
    .x         (x[9:0]),
    .y         (y[GRID_W-1:0]),
    .frame_cnt (frame_cnt),
    .rgb       (rgb)
  );
`else
  mire_pattern u_pat (
    .x   (x[9:0]),
    .y   (y[GRID_W-1:0]),
    .rgb (rgb)
  );
`endif

  assign cyc    = state == WRITE;
  assign stb    = cyc;
  assign cti    = last_beat ? CTI_END : CTI_INCR;
  assign dat_ms = {8'h00, rgb};
  assign sel    = 4'b1111;
  assign we     = 1'b1;
  assign bte    = 2'b00;

endmodule

// File: tb/tb_mire_wshb_writer.sv
// Bench for mire_wshb_writer: full-size and 10x10 instances
// checked against a pixel-stream reference model.
module tb_mire_wshb_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, ack, use_b;
  logic rst_a, rst_b;
  assign rst_a = rst | use_b;
  assign rst_b = rst | ~use_b;

  logic [31:0] adr_a, dat_a, adr_b, dat_b;
  logic [3:0]  sel_a, sel_b;
  logic        we_a, we_b, cyc_a, cyc_b, stb_a, stb_b, fd_a, fd_b;
  logic [2:0]  cti_a, cti_b;
  logic [1:0]  bte_a, bte_b;

  mire_wshb_writer u_a (
    .clk(clk), .rst(rst_a), .en(en), .adr(adr_a), .dat_ms(dat_a),
    .sel(sel_a), .we(we_a), .cyc(cyc_a), .stb(stb_a), .cti(cti_a),
    .bte(bte_a), .ack(ack), .frame_done(fd_a)
  );

  mire_wshb_writer #(.HDISP(10), .VDISP(10), .BURST_LEN(64)) u_b (
    .clk(clk), .rst(rst_b), .en(en), .adr(adr_b), .dat_ms(dat_b),
    .sel(sel_b), .we(we_b), .cyc(cyc_b), .stb(stb_b), .cti(cti_b),
    .bte(bte_b), .ack(ack), .frame_done(fd_b)
  );

  logic [31:0] m_adr, m_dat;
  logic [3:0]  m_sel;
  logic        m_we, m_cyc, m_stb, m_fd;
  logic [2:0]  m_cti;
  logic [1:0]  m_bte;
  assign m_adr = use_b ? adr_b : adr_a;
  assign m_dat = use_b ? dat_b : dat_a;
  assign m_sel = use_b ? sel_b : sel_a;
  assign m_we  = use_b ? we_b  : we_a;
  assign m_cyc = use_b ? cyc_b : cyc_a;
  assign m_stb = use_b ? stb_b : stb_a;
  assign m_fd  = use_b ? fd_b  : fd_a;
  assign m_cti = use_b ? cti_b : cti_a;
  assign m_bte = use_b ? bte_b : bte_a;

  int checks = 0;
  int failures = 0;

  // reference model state
  int h, n, bl, smax, stall_left;
  int k, b, fc, nburst, lastlen, fdcount, dut_fd;
  int stop_k = -1;
  bit cyc_exp, fd_exp, hit;

  typedef struct {
    int          pix;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [2:0]  cti;
  } vec_t;
  vec_t tv[8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pat(input int x, input int y,
                                      input int f);
    int xs = (x + f) % 1024;
    int i;
    if (x % 16 == 0 || y % 16 == 0)
      return 32'h00FFFFFF;
    i = (xs / 128) % 8;
    return {8'h00, (i & 4) != 0 ? 8'hFF : 8'h00,
                   (i & 2) != 0 ? 8'hFF : 8'h00,
                   (i & 1) != 0 ? 8'hFF : 8'h00};
  endfunction

  task automatic step();
    bit a_en, a_ack, a_rst, last;
    int nb;
    @(posedge clk);
    a_en = en; a_ack = ack; a_rst = rst;
    @(negedge clk);
    fd_exp = 0;
    hit = 0;
    if (a_rst) begin
      k = 0; b = 0; fc = 0; nburst = 0; cyc_exp = 0;
    end else if (!cyc_exp) begin
      cyc_exp = a_en;
    end else if (a_ack) begin
      last = (b == bl - 1) || (k == n - 1);
      if (last) begin nburst++; lastlen = b + 1; end
      b = last ? 0 : b + 1;
      if (k == n - 1) begin
        nb = (n + bl - 1) / bl;
        fd_exp = 1;
        fdcount++;
        chk("bursts_per_frame", nburst, nb);
        chk("last_burst_len", lastlen, n - (nb - 1) * bl);
        nburst = 0;
        k = 0;
`ifdef MIRE_ANIM_EN
        fc = (fc + 1) % 1024;
`endif
      end else begin
        k++;
      end
      if (last) cyc_exp = 0;
    end
    if (m_fd) dut_fd++;
    chk("cyc", m_cyc, cyc_exp);
    chk("stb", m_stb, cyc_exp);
    chk("frame_done", m_fd, fd_exp);
    if (a_rst) begin
      chk("rst_adr", m_adr, 0);
      chk("rst_cti", m_cti, 3'b010);
    end
    if (cyc_exp) begin
      chk("adr", m_adr, 4 * k);
      chk("dat", m_dat, pat(k % h, k / h, fc));
      chk("cti", m_cti, (b == bl - 1 || k == n - 1) ? 7 : 2);
      chk("sel", m_sel, 15);
      chk("we", m_we, 1);
      chk("bte", m_bte, 0);
      if (k == stop_k) hit = 1;
    end
    if (hit) begin
      ack = 0;
    end else if (stall_left == 0) begin
      ack = 1;
      stall_left = $urandom_range(0, smax);
    end else begin
      ack = 0;
      stall_left--;
    end
  endtask

  task automatic run_until(input int target, input int bound,
                           input string nm);
    stop_k = target;
    hit = 0;
    for (int i = 0; i < bound; i++) begin
      step();
      if (hit) break;
    end
    stop_k = -1;
    if (!hit) begin
      checks++;
      failures++;
      $display("FAIL %s: timeout, pixel %0d not reached", nm, target);
    end
  endtask

  initial begin
    tv[0] = '{0,     32'h0000_0000, 32'h00FF_FFFF, 3'b010};
    tv[1] = '{63,    32'h0000_00FC, 32'h00FF_FFFF, 3'b111};
    tv[2] = '{64,    32'h0000_0100, 32'h00FF_FFFF, 3'b010};
    tv[3] = '{13601, 32'h0000_D484, 32'h0000_0000, 3'b010};
    tv[4] = '{13729, 32'h0000_D684, 32'h0000_00FF, 3'b010};
    tv[5] = '{13900, 32'h0000_D930, 32'h0000_FF00, 3'b010};
    tv[6] = '{14255, 32'h0000_DEBC, 32'h00FF_00FF, 3'b010};
    tv[7] = '{14399, 32'h0000_E0FC, 32'h00FF_FF00, 3'b111};

    rst = 1; en = 0; ack = 0; use_b = 0;
    h = 800; n = 800 * 480; bl = 64; smax = 0; stall_left = 0;
    k = 0; b = 0; fc = 0; nburst = 0; lastlen = 0;
    fdcount = 0; dut_fd = 0; cyc_exp = 0;
    step();
    step();
    rst = 0;
    en = 1;

    for (int i = 0; i < 8; i++) begin
      run_until(tv[i].pix, 20000, "tbl_reach");
      chk($sformatf("tbl%0d_adr", i), m_adr, tv[i].adr);
      chk($sformatf("tbl%0d_dat", i), m_dat, tv[i].dat);
      chk($sformatf("tbl%0d_cti", i), m_cti, tv[i].cti);
    end

    // small frame with random stalls
    rst = 1; use_b = 1;
    h = 10; n = 100; bl = 64; smax = 5; stall_left = 0;
    step();
    rst = 0;
    fdcount = 0; dut_fd = 0;
    for (int i = 0; i < 5000; i++) begin
      step();
      if (fdcount == 3) break;
    end
    chk("frames_model", fdcount, 3);
    chk("frame_pulses", dut_fd, 3);

    run_until(99, 1000, "last_pix");
    chk("last_pix_cti", m_cti, 3'b111);
    chk("last_pix_adr", m_adr, 32'd396);

    // en dropped mid-burst: burst finishes, then stays idle
    run_until(20, 1000, "mid_burst");
    en = 0;
    for (int i = 0; i < 300; i++) step();
    chk("idle_cyc", m_cyc, 0);
    chk("idle_adr", m_adr, 32'd256);
    en = 1;
    step();
    chk("resume_cyc", m_cyc, 1);
    run_until(70, 2000, "resume");

    // reset mid-burst
    rst = 1;
    step();
    chk("rst_drop_cyc", m_cyc, 0);
    step();
    rst = 0;
    step();
    chk("restart_cyc", m_cyc, 1);
    chk("restart_adr", m_adr, 0);
    for (int i = 0; i < 300; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
